nibble_serial_tx: RTL

- Transmit side of the team's 4-bit register datapath.
- Takes a parallel word captured on a LOAD strobe and shifts it out on a single serial line.
- Frame format: start bit, data bits LSB first, stop bit.
- Sits between a loadable register stage and an off-board or inter-block serial link; the matching receiver reassembles the word.

---
 rtl/nibble_serial_tx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/nibble_serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, DATA_WIDTH data bits LSB first, stop bit.
// Define NIBBLE_SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module nibble_serial_tx #(
    parameter int unsigned DATA_WIDTH   = 4,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  load,
    output logic                  busy,
    output logic                  tx,
    output logic                  sent
);

    localparam int unsigned CycW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CycW-1:0] CycLast = CycW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic [CycW-1:0]       cyc_q, cyc_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  sent_q, sent_d;
    logic                  cyc_last;
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    assign cyc_last = (cyc_q == CycLast);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        sent_d  = 1'b0;
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif

        if (state_q != StIdle) begin
            cyc_d = cyc_last ? '0 : cyc_q + CycW'(1);
        end

        case (state_q)
            StIdle: begin
                if (load) begin
                    shift_d = din;
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = StStart;
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
                    parity_d = ^din;
`endif
                end
            end
            StStart: begin
                if (cyc_last) state_d = StData;
            end
            StData: begin
                if (cyc_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BitLast) begin
                        bit_d = '0;
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
            StParity: begin
                if (cyc_last) state_d = StStop;
            end
`endif
            StStop: begin
                if (cyc_last) begin
                    state_d = StIdle;
                    sent_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        busy_d = (state_d != StIdle);
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
            StParity: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            sent_q  <= sent_d;
        end
    end

`ifdef NIBBLE_SERIAL_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (clr) parity_q <= 1'b0;
        else     parity_q <= parity_d;
    end
`endif

    assign tx   = tx_q;
    assign busy = busy_q;
    assign sent = sent_q;

endmodule
